// File: rtl/lights_pkg.sv
// Colour-code constants shared by the LIGHTS block and its PWM driver.
// The bit indices select a channel; the codes name the two extreme colours.
package lights_pkg;

  localparam int unsigned COLOUR_R = 2;
  localparam int unsigned COLOUR_G = 1;
  localparam int unsigned COLOUR_B = 0;

  localparam logic [2:0] COLOUR_OFF   = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

endpackage

// File: rtl/colour_pwm_driver_pwm_channel.sv
// One LED channel: the duty register, the saturating linear ramp toward the
// target, and the registered PWM compare against the shared period counter.
module pwm_channel
  import lights_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic             boundary_i,
  input  logic             enable_i,
  input  logic [PWM_W-1:0] target_i,
  output logic             led_o,
  output logic             busy_o
);

  localparam int EW       = PWM_W + 1;
  localparam int STEP_SAT = (STEP > (2 ** PWM_W)) ? (2 ** PWM_W) : STEP;

  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q, led_d;
  logic [EW-1:0]    dutyExt, targetExt, diff, delta;

  // The step is clipped to the remaining distance, so the ramp lands exactly on the target.
  always_comb begin
    duty_d    = duty_q;
    dutyExt   = {1'b0, duty_q};
    targetExt = {1'b0, target_i};
    if (dutyExt < targetExt) begin
      diff = targetExt - dutyExt;
    end else begin
      diff = dutyExt - targetExt;
    end
    delta = (diff < EW'(STEP_SAT)) ? diff : EW'(STEP_SAT);
    if (boundary_i && enable_i) begin
      if (dutyExt < targetExt) begin
        duty_d = PWM_W'(dutyExt + delta);
      end else if (dutyExt > targetExt) begin
        duty_d = PWM_W'(dutyExt - delta);
      end
    end
    led_d = enable_i && (cnt_i < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = (duty_q != target_i);

endmodule

// File: rtl/colour_pwm_driver.sv
// Drives the RGB LED pins from the 3-bit colour code, cross-fading each
// channel linearly between brightness levels one bounded step per PWM period.
module colour_pwm_driver
  import lights_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int MAX_DUTY = 255,
  parameter int STEP     = 8,
  parameter int DIV      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((2 ** PWM_W) - 2);
  localparam logic [PWM_W-1:0] FULL     = PWM_W'(MAX_DUTY);

  logic [2:0]       colour_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             tick, boundary;
  logic [2:0]       chLed, chBusy;
  logic [PWM_W-1:0] targetR, targetG, targetB;

  // Disabling parks the prescaler and counter at 0 so re-enabling starts a clean period.
  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    tick     = enable && (pre_q == PRE_W'(DIV - 1));
    boundary = tick && (cnt_q == CNT_LAST);
    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      colour_q <= COLOUR_OFF;
      pre_q    <= '0;
      cnt_q    <= '0;
    end else begin
      colour_q <= colour;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
    end
  end

  assign targetR = colour_q[COLOUR_R] ? FULL : '0;
  assign targetG = colour_q[COLOUR_G] ? FULL : '0;
  assign targetB = colour_q[COLOUR_B] ? FULL : '0;

  pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_red (
    .clk(clk), .rst_n(rst_n), .cnt_i(cnt_q), .boundary_i(boundary),
    .enable_i(enable), .target_i(targetR),
    .led_o(chLed[COLOUR_R]), .busy_o(chBusy[COLOUR_R])
  );

  pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_green (
    .clk(clk), .rst_n(rst_n), .cnt_i(cnt_q), .boundary_i(boundary),
    .enable_i(enable), .target_i(targetG),
    .led_o(chLed[COLOUR_G]), .busy_o(chBusy[COLOUR_G])
  );

  pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_blue (
    .clk(clk), .rst_n(rst_n), .cnt_i(cnt_q), .boundary_i(boundary),
    .enable_i(enable), .target_i(targetB),
    .led_o(chLed[COLOUR_B]), .busy_o(chBusy[COLOUR_B])
  );

  assign led_r = chLed[COLOUR_R];
  assign led_g = chLed[COLOUR_G];
  assign led_b = chLed[COLOUR_B];
  assign busy  = |chBusy;

endmodule

// File: tb/tb_colour_pwm_driver.sv
// Directed bench for colour_pwm_driver at PWM_W=4, MAX_DUTY=15, STEP=5, DIV=1;
// duty is observed as the count of LED-high cycles over a 15-cycle period.
module tb_colour_pwm_driver;

  logic       clk;
  logic       rst_n;
  logic [2:0] colour;
  logic       enable;
  logic       led_r, led_g, led_b, busy;

  int total = 0;
  int bad   = 0;

  colour_pwm_driver #(.PWM_W(4), .MAX_DUTY(15), .STEP(5), .DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .colour(colour), .enable(enable),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances n cycles, sampling on each falling edge, and tallies high cycles.
  task automatic run_window(input int n, output int r, output int g, output int b, output int bz);
    r = 0; g = 0; b = 0; bz = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      r  += int'(led_r);
      g  += int'(led_g);
      b  += int'(led_b);
      bz += int'(busy);
    end
  endtask

  task automatic do_reset(input logic [2:0] c);
    @(negedge clk);
    rst_n = 1'b0; colour = c; enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; colour = 3'b111; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({led_r, led_g, led_b} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_leds cycle %0d: got %b want 000", i, {led_r, led_g, led_b});
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b want 0", i, busy);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_fade_up();
    int r, g, b, bz;
    int expR[4]  = '{0, 5, 10, 15};
    int expBz[4] = '{15, 15, 14, 0};
    do_reset(3'b100);
    for (int p = 0; p < 4; p++) begin
      run_window(15, r, g, b, bz);
      total++;
      if (r !== expR[p]) begin
        bad++;
        $display("[TB] FAIL fade_up_red p%0d: got %0d want %0d", p, r, expR[p]);
      end
      total++;
      if ((g + b) !== 0) begin
        bad++;
        $display("[TB] FAIL fade_up_gb p%0d: got g=%0d b=%0d want 0", p, g, b);
      end
      total++;
      if (bz !== expBz[p]) begin
        bad++;
        $display("[TB] FAIL fade_up_busy p%0d: got %0d want %0d", p, bz, expBz[p]);
      end
    end
  endtask

  task automatic test_cross_fade();
    int r, g, b, bz;
    int expR[4]  = '{15, 10, 5, 0};
    int expG[4]  = '{0, 5, 10, 15};
    int expBz[4] = '{15, 15, 14, 0};
    colour = 3'b010;
    for (int p = 0; p < 4; p++) begin
      run_window(15, r, g, b, bz);
      total++;
      if (r !== expR[p] || g !== expG[p] || b !== 0) begin
        bad++;
        $display("[TB] FAIL cross_fade p%0d: got r=%0d g=%0d b=%0d want r=%0d g=%0d b=0",
                 p, r, g, b, expR[p], expG[p]);
      end
      total++;
      if (bz !== expBz[p]) begin
        bad++;
        $display("[TB] FAIL cross_fade_busy p%0d: got %0d want %0d", p, bz, expBz[p]);
      end
    end
  endtask

  task automatic test_reversal();
    int r, g, b, bz;
    logic [2:0] col[8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001};
    int expB[8] = '{0, 5, 10, 5, 0, 5, 10, 15};
    int expG[8] = '{15, 10, 5, 0, 0, 0, 0, 0};
    for (int p = 0; p < 8; p++) begin
      colour = col[p];
      run_window(15, r, g, b, bz);
      total++;
      if (b !== expB[p] || g !== expG[p] || r !== 0) begin
        bad++;
        $display("[TB] FAIL reversal p%0d: got r=%0d g=%0d b=%0d want r=0 g=%0d b=%0d",
                 p, r, g, b, expG[p], expB[p]);
      end
    end
  endtask

  task automatic test_enable();
    int r, g, b, bz;
    do_reset(3'b100);
    run_window(15, r, g, b, bz);
    run_window(5, r, g, b, bz);
    total++;
    if (r !== 5) begin
      bad++;
      $display("[TB] FAIL enable_pre_red: got %0d want 5", r);
    end
    enable = 1'b0;
    run_window(1, r, g, b, bz);
    total++;
    if ((r + g + b) !== 0) begin
      bad++;
      $display("[TB] FAIL enable_off_next_edge: got r=%0d g=%0d b=%0d want 0", r, g, b);
    end
    run_window(40, r, g, b, bz);
    total++;
    if ((r + g + b) !== 0 || bz !== 40) begin
      bad++;
      $display("[TB] FAIL enable_hold: got leds=%0d busy=%0d want leds=0 busy=40", r + g + b, bz);
    end
    enable = 1'b1;
    run_window(15, r, g, b, bz);
    total++;
    if (r !== 5) begin
      bad++;
      $display("[TB] FAIL enable_resume_frozen: got %0d want 5", r);
    end
    run_window(11, r, g, b, bz);
    total++;
    if (r !== 10) begin
      bad++;
      $display("[TB] FAIL enable_resume_step: got %0d want 10", r);
    end
  endtask

  task automatic test_reset_mid_fade();
    int r, g, b, bz;
    int expR[3] = '{0, 5, 10};
    rst_n = 1'b0;
    run_window(1, r, g, b, bz);
    total++;
    if ((r + g + b) !== 0 || bz !== 0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got leds=%0d busy=%0d want 0 0", r + g + b, bz);
    end
    rst_n = 1'b1;
    colour = 3'b100;
    for (int p = 0; p < 3; p++) begin
      run_window(15, r, g, b, bz);
      total++;
      if (r !== expR[p]) begin
        bad++;
        $display("[TB] FAIL mid_reset_ramp p%0d: got %0d want %0d", p, r, expR[p]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; colour = 3'b000; enable = 1'b1;
    test_reset();
    test_fade_up();
    test_cross_fade();
    test_reversal();
    test_enable();
    test_reset_mid_fade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/colour_pwm_driver.md
# colour_pwm_driver

Downstream stage of the dynamic LED lights block: consumes its 3-bit `colour` code and drives the three physical RGB LED pins with pulse-width modulation. When the code changes, each channel cross-fades linearly from its current brightness to the new target instead of switching abruptly. This makes the colour sequence visually smooth on the board.

## Interface
Parameters:
- `PWM_W`, 8: PWM counter width. Period is 2^PWM_W − 1 ticks.
- `MAX_DUTY`, 255: duty of a fully-on channel. Legal range is 1 .. 2^PWM_W − 1.
- `STEP`, 8: maximum duty change per channel per PWM period. Must be ≥ 1.
- `DIV`, 1: clock cycles per PWM tick. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `colour` in 3: colour code. Bit 2 is red, bit 1 is green, bit 0 is blue.
- `enable` in 1: low blanks the outputs and freezes the fade.
- `led_r`, `led_g`, `led_b` out 1 each: registered PWM outputs. High means LED on.
- `busy` out 1: high while any channel duty differs from its target.

## Operation
- **Colour sampling.** `colour` is registered every cycle into `colour_q`.
- **Target per channel.** The target is `MAX_DUTY` if the channel's bit in `colour_q` is 1, else 0. So 3'b000 is all off and 3'b111 is white.
- **Prescaler.** Counts 0..DIV−1 and emits `tick` when it is at DIV−1, then wraps to 0.
- **PWM counter `cnt`.** Advances on `tick` through 0..2^PWM_W−2, then wraps to 0. The wrap tick is the period boundary.
- **Output compare.** `led_x` is registered as `cnt < duty_x` every cycle while `enable` is high.
  - duty 0 gives a constant 0.
  - duty 2^PWM_W−1 gives a constant 1.
- **Fade.** On each period boundary every channel updates independently:
  - `duty = duty + min(STEP, target − duty)` if duty < target.
  - `duty = duty − min(STEP, duty − target)` if duty > target.
  - Otherwise duty holds.
  - Arithmetic is PWM_W+1 bits wide and never overshoots or wraps.
- **`busy`.** Combinational OR of (duty_x ≠ target_x) over the three channels.
- **Target change mid-fade.** The new target takes effect at the next period boundary. The ramp continues from the current duty with no jump.
- **`enable` low.**
  - Outputs go to 0 on the next edge.
  - Prescaler and `cnt` are held at 0.
  - Duties are frozen.
  - `busy` still reflects the duty/target comparison.
- **`enable` rising.** PWM restarts from `cnt` = 0. Fading resumes at the first period boundary after that.
- **Reset** (`rst_n` = 0 at an edge), whether idle or mid-fade:
  - `colour_q`, prescaler, `cnt` and all duties are cleared to 0.
  - `led_r`, `led_g`, `led_b` are cleared to 0.
  - `busy` is 0 while reset is held.
  - After release, a non-zero `colour` fades up from 0.

## Timing
- `colour` change sampled at edge t: `colour_q` updates at t. `busy` rises combinationally after edge t.
- Duty changes only on the edge that performs the period-boundary tick. The new duty first affects `led_x` at the following edge, which is 1 cycle of output latency.
- Full fade time is ceil(MAX_DUTY / STEP) periods of (2^PWM_W − 1)·DIV cycles each.
- `busy` falls in the same cycle the last channel's duty reaches its target.
- Reset values: `led_r` = `led_g` = `led_b` = 0, `busy` = 0.

## Structure
- **Shared package `lights_pkg`.** Holds the colour bit-index constants (R = 2, G = 1, B = 0) and the 3-bit colour code localparams (OFF = 3'b000, WHITE = 3'b111). The LIGHTS block uses the same package.
- **Sub-module `pwm_channel`.** Contains the duty register, saturating ramp and output compare. It takes `cnt`, the boundary strobe, `enable` and `target`, and produces `led` and a per-channel busy.
- **Top level.** Instantiates `pwm_channel` three times. Owns `colour_q`, the prescaler and `cnt`.

## Test plan
All scenarios use PWM_W = 4 (period 15), MAX_DUTY = 15, STEP = 5, DIV = 1.
1. **Reset.** Hold `rst_n` = 0 for 3 cycles with `colour` = 3'b111 and `enable` = 1 → all LED outputs and `busy` are 0. After release, `busy` rises on the first edge.
2. **Fade up.** From reset, apply `colour` = 3'b100 → red duty goes 5, 10, 15 at three consecutive period boundaries. `led_r` is high 5/15, then 10/15, then constant. `busy` falls when red duty reaches 15. Green and blue stay 0 throughout.
3. **Cross-fade.** At steady 3'b100, apply 3'b010 → red goes 15, 10, 5, 0 while green goes 0, 5, 10, 15 on the same boundaries. `busy` is high for exactly 3 periods.
4. **Reversal.** Apply 3'b001 when blue duty = 10 and rising, then 3'b000 → blue goes 10, 5, 0 with no overshoot. Then apply 3'b001 → blue goes 5, 10, 15.
5. **Enable.** Drop `enable` mid-fade at duty 5 → LEDs are 0 on the next edge and the duty stays 5 for 40 cycles. Re-raise `enable` → `cnt` restarts at 0 and the duty steps to 10 at the next boundary.
6. **Reset mid-fade.** Assert `rst_n` = 0 at duty 10 → next edge has all duties 0 and all LEDs 0. After release with `colour` = 3'b100, red climbs from 5.
